// File: rtl/pe_acc_if.sv
// Product-beat input and dot-product result handshake bundle for pe_acc.
interface pe_acc_if;
  logic          acc_valid_i;
  logic          acc_ready_o;
  logic [1023:0] acc_data_i;
  logic          acc_last_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [47:0]   res_data_o;
  logic [15:0]   res_cnt_o;

  // Upstream multiplier array / downstream writeback side.
  modport master (
    output acc_valid_i, acc_data_i, acc_last_i, res_ready_i,
    input  acc_ready_o, res_valid_o, res_data_o, res_cnt_o
  );

  // Accumulator side.
  modport slave (
    input  acc_valid_i, acc_data_i, acc_last_i, res_ready_i,
    output acc_ready_o, res_valid_o, res_data_o, res_cnt_o
  );
endinterface

// File: rtl/pe_acc.sv
// Reduces a 32-lane int32 product beat through a two-stage adder tree and
// accumulates beat sums over a multi-beat dot product; the beat flagged last
// produces one 48-bit result via valid/ready. The whole pipe stalls together.
module pe_acc (
  input  logic     clk,
  input  logic     rst_n,
  pe_acc_if.slave  bus
);

  logic adv;
  logic accept;

  logic signed [34:0] lane_ext [32];
  logic signed [34:0] psum     [4];
  logic signed [36:0] beat_sum;

  logic signed [34:0] s1_psum_q [4];
  logic signed [34:0] s1_psum_d [4];
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q,  s1_last_d;

  logic signed [36:0] s2_sum_q,   s2_sum_d;
  logic               s2_valid_q, s2_valid_d;
  logic               s2_last_q,  s2_last_d;

  logic [47:0] acc_q,   acc_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        first_q, first_d;
  logic [47:0] nxt;
  logic [15:0] nxt_cnt;

  logic        res_valid_q, res_valid_d;
  logic [47:0] res_data_q,  res_data_d;
  logic [15:0] res_cnt_q,   res_cnt_d;

  // Sign-extend every lane to the partial-sum width.
  for (genvar i = 0; i < 32; i++) begin : g_lane
    assign lane_ext[i] = 35'($signed(bus.acc_data_i[i*32 +: 32]));
  end

  // Stage-1 tree level: four 8-lane partial sums.
  for (genvar g = 0; g < 4; g++) begin : g_psum
    assign psum[g] = lane_ext[g*8+0] + lane_ext[g*8+1] + lane_ext[g*8+2] + lane_ext[g*8+3]
                   + lane_ext[g*8+4] + lane_ext[g*8+5] + lane_ext[g*8+6] + lane_ext[g*8+7];
  end

  // Global stall: everything advances unless a result is waiting on downstream.
  always_comb begin
    adv    = !res_valid_q || bus.res_ready_i;
    accept = bus.acc_valid_i && adv;
  end

  // Pipeline stage registers: partial sums, then the full beat sum.
  always_comb begin
    s1_psum_d  = s1_psum_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s2_sum_d   = s2_sum_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    beat_sum   = 37'(s1_psum_q[0]) + 37'(s1_psum_q[1])
               + 37'(s1_psum_q[2]) + 37'(s1_psum_q[3]);
    if (adv) begin
      s1_valid_d = bus.acc_valid_i;
      s1_last_d  = bus.acc_valid_i && bus.acc_last_i;
      if (accept) s1_psum_d = psum;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (s1_valid_q) s2_sum_d = beat_sum;
    end
  end

  // Accumulate beat sums; the last beat publishes the result and rearms first.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    nxt         = (first_q ? '0 : acc_q) + 48'(s2_sum_q);
    if (first_q)          nxt_cnt = 16'd1;
    else if (cnt_q == '1) nxt_cnt = cnt_q;
    else                  nxt_cnt = cnt_q + 16'd1;
    if (adv) begin
      // adv with a pending result implies it is being consumed this cycle;
      // a new last result overrides the clear below.
      res_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          res_data_d  = nxt;
          res_cnt_d   = nxt_cnt;
          res_valid_d = 1'b1;
          first_d     = 1'b1;
        end else begin
          acc_d   = nxt;
          cnt_d   = nxt_cnt;
          first_d = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_psum_q   <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      s1_psum_q   <= s1_psum_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_sum_q    <= s2_sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign bus.acc_ready_o = adv;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_cnt_o   = res_cnt_q;

endmodule

// File: tb/tb_pe_acc.sv
// Directed and random checks of pe_acc against a queue-based reference:
// each accepted last beat schedules its result three advancing edges later.
module tb_pe_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pe_acc_if bus ();

  pe_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic [15:0] cnt;
    int          dly;
  } res_t;

  int checks   = 0;
  int failures = 0;

  // reference model state
  longint      m_sum   = 0;
  int          m_beats = 0;
  res_t        pend[$];
  logic        m_valid = 1'b0;
  logic [47:0] m_data  = '0;
  logic [15:0] m_cnt   = '0;

  // results handed downstream by the DUT, {cnt, data}
  logic [63:0] dut_res[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] fill(input logic [31:0] v);
    return {32{v}};
  endfunction

  function automatic longint lane_sum(input logic [1023:0] d);
    longint s;
    logic signed [31:0] w;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      w = d[i*32 +: 32];
      s = s + longint'(w);
    end
    return s;
  endfunction

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic tick(input logic v, input logic [1023:0] d, input logic l,
                      input logic rdy, output logic accepted);
    logic  m_adv;
    res_t  r;
    logic [63:0] sum64;
    bus.acc_valid_i = v;
    bus.acc_data_i  = d;
    bus.acc_last_i  = l;
    bus.res_ready_i = rdy;
    #1;
    m_adv = !m_valid || rdy;
    check("acc_ready", 64'(bus.acc_ready_o), 64'(m_adv));
    accepted = v && m_adv;
    if (bus.res_valid_o && rdy) dut_res.push_back({bus.res_cnt_o, bus.res_data_o});
    @(posedge clk);
    if (m_adv) begin
      if (accepted) begin
        m_sum   = m_sum + lane_sum(d);
        m_beats = (m_beats >= 65535) ? 65535 : m_beats + 1;
        if (l) begin
          sum64  = m_sum;
          r.data = sum64[47:0];
          r.cnt  = 16'(m_beats);
          r.dly  = 3;
          pend.push_back(r);
          m_sum   = 0;
          m_beats = 0;
        end
      end
      foreach (pend[i]) pend[i].dly = pend[i].dly - 1;
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].dly == 0) begin
        m_valid = 1'b1;
        m_data  = pend[0].data;
        m_cnt   = pend[0].cnt;
        void'(pend.pop_front());
      end
    end
    @(negedge clk);
    check("res_valid", 64'(bus.res_valid_o), 64'(m_valid));
    if (m_valid) begin
      check("res_data", 64'(bus.res_data_o), 64'(m_data));
      check("res_cnt", 64'(bus.res_cnt_o), 64'(m_cnt));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, rdy, a);
  endtask

  // Present a beat and hold it until taken, within a bounded number of cycles.
  task automatic send_beat(input logic [1023:0] d, input logic l, input logic rdy);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) tick(1'b1, d, l, rdy, a);
    check("send_timeout", 64'(a), 64'(1));
  endtask

  task automatic do_reset();
    bus.acc_valid_i = 1'b0;
    bus.acc_last_i  = 1'b0;
    bus.acc_data_i  = '0;
    bus.res_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_acc_ready", 64'(bus.acc_ready_o), 64'(1));
    check("rst_res_valid", 64'(bus.res_valid_o), 64'(0));
    check("rst_res_data", 64'(bus.res_data_o), 64'(0));
    check("rst_res_cnt", 64'(bus.res_cnt_o), 64'(0));
    m_sum   = 0;
    m_beats = 0;
    pend.delete();
    m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic a;
    logic [47:0] held;
    logic [1023:0] rd;
    logic rl, have, rdy;

    @(negedge clk);
    do_reset();

    // four beats of lane value 1
    dut_res.delete();
    for (int b = 1; b <= 4; b++) send_beat(fill(32'h1), b == 4, 1'b1);
    idle(5, 1'b1);
    check("four_beat_count", 64'(dut_res.size()), 64'(1));
    if (dut_res.size() > 0) check("four_beat_res", dut_res[0], {16'd4, 48'd128});

    // single beat of -1 lanes
    dut_res.delete();
    send_beat(fill(32'hFFFF_FFFF), 1'b1, 1'b1);
    idle(5, 1'b1);
    check("neg_count", 64'(dut_res.size()), 64'(1));
    if (dut_res.size() > 0) check("neg_res", dut_res[0], {16'd1, 48'hFFFF_FFFF_FFE0});

    // 2048 and 4096 beats of INT32_MIN lanes
    dut_res.delete();
    for (int b = 1; b <= 2048; b++) send_beat(fill(32'h8000_0000), b == 2048, 1'b1);
    for (int b = 1; b <= 4096; b++) send_beat(fill(32'h8000_0000), b == 4096, 1'b1);
    idle(5, 1'b1);
    check("long_count", 64'(dut_res.size()), 64'(2));
    if (dut_res.size() > 1) begin
      check("long_2048", dut_res[0], {16'd2048, 48'h8000_0000_0000});
      check("long_4096", dut_res[1], {16'd4096, 48'h0});
    end

    // result held back by downstream while upstream keeps offering a beat
    dut_res.delete();
    tick(1'b1, fill(32'd5), 1'b1, 1'b0, a);
    for (int i = 0; i < 10 && !bus.res_valid_o; i++) tick(1'b0, '0, 1'b0, 1'b0, a);
    check("stall_pending", 64'(bus.res_valid_o), 64'(1));
    held = bus.res_data_o;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, fill(32'd2), 1'b0, 1'b0, a);
      check("stall_ready_low", 64'(bus.acc_ready_o), 64'(0));
      check("stall_data_hold", 64'(bus.res_data_o), 64'(held));
    end
    send_beat(fill(32'd2), 1'b0, 1'b1);
    send_beat(fill(32'd2), 1'b1, 1'b1);
    idle(5, 1'b1);
    check("stall_count", 64'(dut_res.size()), 64'(2));
    if (dut_res.size() > 1) begin
      check("stall_first", dut_res[0], {16'd1, 48'd160});
      check("stall_second", dut_res[1], {16'd2, 48'd128});
    end

    // reset aborts a partial dot product
    dut_res.delete();
    send_beat(fill(32'd1), 1'b0, 1'b1);
    send_beat(fill(32'd1), 1'b0, 1'b1);
    do_reset();
    send_beat(fill(32'd1), 1'b1, 1'b1);
    idle(5, 1'b1);
    check("abort_count", 64'(dut_res.size()), 64'(1));
    if (dut_res.size() > 0) check("abort_res", dut_res[0], {16'd1, 48'd32});

    // back-to-back single-beat dot products
    dut_res.delete();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, fill(32'(k)), 1'b1, 1'b1, a);
      check("b2b_accept", 64'(a), 64'(1));
      if (k >= 3) check("b2b_valid", 64'(bus.res_valid_o), 64'(1));
    end
    idle(5, 1'b1);
    check("b2b_count", 64'(dut_res.size()), 64'(10));
    foreach (dut_res[i]) check("b2b_res", dut_res[i], {16'd1, 48'(32 * (i + 1))});

    // random traffic and backpressure
    have = 1'b0;
    rd   = '0;
    rl   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 32; i++) rd[i*32 +: 32] = $urandom;
        rl   = ($urandom_range(0, 3) == 0);
        have = 1'b1;
      end
      rdy = ($urandom_range(0, 3) != 0);
      tick(have, have ? rd : '0, have && rl, rdy, a);
      if (a) have = 1'b0;
    end
    send_beat(fill(32'd7), 1'b1, 1'b1);
    idle(6, 1'b1);
    check("drain_empty", 64'(pend.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
